dual_port_ram_stream_reader: RTL and testbench
==============================================

# dual_port_ram_stream_reader

Read-side controller for the banked simple dual-port RAM used in the openCV line/frame buffers. On a start command it sweeps a contiguous run of elements, element index first and then word address, starting at (baseAddr, baseElm). It drives the RAM read port (raddr, raddrElm) and absorbs the RAM's one-cycle registered read latency. Elements (q[0] in non-block output mode) are delivered on a valid/ready stream with full throughput and lossless backpressure. It sits between the buffer RAM and downstream filter kernels.

## Interface
- ADDR_WIDTH, 1, RAM word address width.
- WORD_SIZE, 8, element width in bits.
- WORDS, 2, elements per RAM word; power of two, at least 2.
- ELM_W, globalDefinitions::log2(WORDS), element index width. Derived; not overridden.
- LEN_WIDTH, ADDR_WIDTH+ELM_W+1, width of the element count.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  command strobe; accepted only in IDLE.
- baseAddr  in  ADDR_WIDTH  first word address, sampled with start.
- baseElm  in  ELM_W  first element index, sampled with start.
- length  in  LEN_WIDTH  number of elements to read, sampled with start.
- raddr  out  ADDR_WIDTH  RAM read address.
- raddrElm  out  ELM_W  RAM read element select.
- q  in  WORD_SIZE  RAM read data (element 0 of RAM q); valid one cycle after the address is presented.
- outData  out  WORD_SIZE  stream data.
- outValid  out  1  stream valid.
- outReady  in  1  stream ready.
- outLast  out  1  marks the final element of the command.
- busy  out  1  a command is active.
- done  out  1  one-cycle pulse when the command completes.

## Operation
- States:
  - IDLE: waiting for a command.
  - RUN: issuing reads.
  - DRAIN: all reads issued; waiting for the output buffer to empty.
- IDLE -> RUN on start when length != 0. The block latches base address, base element and length; the remaining-count counter is loaded with length.
- IDLE with start and length == 0: no reads are issued and no stream beats are produced. done pulses on the next cycle; busy stays low.
- Read issue rule in RUN: a read is issued in a cycle when occ + inflight < 3.
  - occ is the registered occupancy of a 3-entry output FIFO, 0 to 3.
  - inflight is a registered 1-bit flag that a read was issued in the previous cycle.
  - The same-cycle pop is not credited.
- An issued read presents the current (addr, elm) on raddr/raddrElm, then updates the counters:
  - elm increments;
  - when elm == WORDS-1, elm wraps to 0 and addr increments;
  - addr wraps modulo 2^ADDR_WIDTH with no error;
  - the remaining count decrements.
- When a read is not issued, raddr/raddrElm hold their last value. The returned q is ignored because inflight is 0.
- The cycle after an issue, q is pushed into the FIFO together with a last flag. The flag is set when that read was the one that took the remaining count to 0.
- RUN -> DRAIN on the issue that takes the remaining count to 0.
- DRAIN -> IDLE on the handshake (outValid && outReady) of the beat with outLast set. done pulses on the following cycle.
- FIFO behaviour:
  - Push and pop in the same cycle are both honoured.
  - The FIFO never overflows; the credit rule guarantees this.
  - outData/outLast come from the FIFO head; outValid = (occ != 0).
- start while busy is ignored, with no effect on the active command.
- Reads only: the block never drives the RAM write port. Data read from an address written in the same cycle follows the RAM's behaviour.

## Timing
- Reset values:
  - state IDLE;
  - raddr = 0, raddrElm = 0;
  - outValid = 0, outData = 0, outLast = 0;
  - busy = 0, done = 0;
  - FIFO empty, inflight = 0.
- Reset asserted mid-command:
  - all outputs take their reset values immediately;
  - in-flight data is discarded;
  - after release the block idles.
- Latency (outReady held high):
  - start sampled at cycle 0;
  - first raddr presented in cycle 1;
  - q valid in cycle 2 and pushed;
  - outValid high from cycle 3.
- Throughput: one element per cycle with outReady held high. The last beat of an N-element command occurs at cycle N+2.
- busy is high from cycle 1 through the cycle of the done pulse, inclusive.
- Backpressure: with outReady low, at most 3 elements are held and issue stops. Issue resumes the cycle after occ + inflight drops below 3.
- outData/outLast are stable while outValid && !outReady.

## Test plan
- WORDS=4, RAM preloaded with element value addr*4+elm; start with base (2,1) and length 6, outReady=1. Required:
  - beats 9,10,11,12,13,14 in cycles 3–8;
  - outLast on 14;
  - done in cycle 9;
  - raddr/raddrElm sequence (2,1),(2,2),(2,3),(3,0),(3,1),(3,2).
- ADDR_WIDTH=2, WORDS=2; base (3,1), length 3. Required: reads (3,1),(0,0),(0,1), showing address wrap.
- Length 10 with outReady toggling 1,0,0,1 repeating. Required:
  - all 10 values in order with none duplicated;
  - occ never above 3;
  - data stable while stalled.
- start with length=0. Required: done pulses at cycle 1, busy stays 0, outValid stays 0. A second start during a busy command is ignored, and the sequence of the active command is unchanged.
- Assert reset in cycle 5 of a 20-element command. Required:
  - outValid, busy and done drop immediately;
  - after release, no stale beats appear;
  - a new 2-element command completes correctly.

Source files
------------

// File: rtl/dual_port_ram_stream_reader_if.sv
// Bundle of command, RAM read-port and output-stream signals for the
// dual-port RAM stream reader. "master" is the reader's view, "slave" is
// the view of the environment (command source, RAM and stream sink).
interface dual_port_ram_stream_reader_if #(
  parameter int ADDR_WIDTH = 1,
  parameter int WORD_SIZE  = 8,
  parameter int WORDS      = 2
);
  localparam int ELM_W     = $clog2(WORDS);
  localparam int LEN_WIDTH = ADDR_WIDTH + ELM_W + 1;

  // command
  logic                  start;
  logic [ADDR_WIDTH-1:0] baseAddr;
  logic [ELM_W-1:0]      baseElm;
  logic [LEN_WIDTH-1:0]  length;
  // RAM read port
  logic [ADDR_WIDTH-1:0] raddr;
  logic [ELM_W-1:0]      raddrElm;
  logic [WORD_SIZE-1:0]  q;
  // output stream
  logic [WORD_SIZE-1:0]  outData;
  logic                  outValid;
  logic                  outReady;
  logic                  outLast;
  // status
  logic                  busy;
  logic                  done;

  modport master (
    input  start, baseAddr, baseElm, length, q, outReady,
    output raddr, raddrElm, outData, outValid, outLast, busy, done
  );

  modport slave (
    output start, baseAddr, baseElm, length, q, outReady,
    input  raddr, raddrElm, outData, outValid, outLast, busy, done
  );
endinterface

// File: rtl/dual_port_ram_stream_reader.sv
// Read-side controller for the banked simple dual-port line/frame buffer RAM.
// A start command sweeps (addr, elm) positions element-first, absorbs the
// RAM's one-cycle read latency and streams the elements out through a
// 3-entry FIFO with full throughput and lossless backpressure.
//
// raddr/raddrElm are registers: the decision to read in a cycle is taken at
// the edge before it, using the occupancy and in-flight flag that will hold
// in that cycle. issue_r marks a cycle whose raddr is a real read.
module dual_port_ram_stream_reader #(
  parameter int ADDR_WIDTH = 1,
  parameter int WORD_SIZE  = 8,
  parameter int WORDS      = 2
) (
  input logic                          clk,
  input logic                          reset,
  dual_port_ram_stream_reader_if.master bus
);
  localparam int ELM_W     = $clog2(WORDS);
  localparam int LEN_WIDTH = ADDR_WIDTH + ELM_W + 1;
  localparam int POS_W     = ADDR_WIDTH + ELM_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state_r;
  logic [ADDR_WIDTH-1:0] next_addr_r;     // next position to read
  logic [ELM_W-1:0]      next_elm_r;
  logic [ADDR_WIDTH-1:0] raddr_r;         // position presented to the RAM
  logic [ELM_W-1:0]      raddr_elm_r;
  logic [LEN_WIDTH-1:0]  remain_r;        // reads not yet scheduled
  logic                  issue_r;         // raddr this cycle is a real read
  logic                  issue_last_r;    // ... and it is the final one
  logic                  inflight_r;      // q this cycle belongs to a read
  logic                  inflight_last_r;
  logic [WORD_SIZE-1:0]  fifo_data_r [3]; // entry 0 is the head
  logic [2:0]            fifo_last_r;
  logic [1:0]            occ_r;
  logic                  valid_r;
  logic                  busy_r;
  logic                  done_r;

  logic [WORD_SIZE-1:0]  fifo_data_s [3];
  logic [2:0]            fifo_last_s;
  logic [1:0]            occ_s;
  logic [1:0]            wr_idx_s;
  logic                  pop_s;
  logic                  credit_ok_s;
  logic                  last_hs_s;
  logic                  start_ok_s;

  // Element-first position step; the word address wraps silently.
  function automatic logic [POS_W-1:0] advance(input logic [ADDR_WIDTH-1:0] addr,
                                               input logic [ELM_W-1:0]      elm);
    logic [ADDR_WIDTH-1:0] a;
    logic [ELM_W-1:0]      e;
    if (elm == ELM_W'(WORDS - 1)) begin
      e = '0;
      a = addr + ADDR_WIDTH'(1);
    end else begin
      e = elm + ELM_W'(1);
      a = addr;
    end
    return {a, e};
  endfunction

  assign pop_s      = valid_r & bus.outReady;
  assign last_hs_s  = pop_s & fifo_last_r[0];
  assign start_ok_s = (state_r == IDLE) & ~busy_r & bus.start;
  assign occ_s      = occ_r - {1'b0, pop_s} + {1'b0, inflight_r};
  // Room for one more read in the coming cycle, counting the one landing now.
  assign credit_ok_s = ({1'b0, occ_s} + {2'b00, issue_r}) < 3'd3;

  // Output FIFO next state: shift out the head on pop, then append returning data.
  always_comb begin
    fifo_data_s[0] = fifo_data_r[0];
    fifo_data_s[1] = fifo_data_r[1];
    fifo_data_s[2] = fifo_data_r[2];
    fifo_last_s    = fifo_last_r;
    wr_idx_s       = occ_r;
    if (pop_s) begin
      fifo_data_s[0] = fifo_data_r[1];
      fifo_data_s[1] = fifo_data_r[2];
      fifo_last_s    = {1'b0, fifo_last_r[2:1]};
      wr_idx_s       = occ_r - 2'd1;
    end else begin
      wr_idx_s       = occ_r;
    end
    if (inflight_r) begin
      case (wr_idx_s)
        2'd0: begin
          fifo_data_s[0] = bus.q;
          fifo_last_s[0] = inflight_last_r;
        end
        2'd1: begin
          fifo_data_s[1] = bus.q;
          fifo_last_s[1] = inflight_last_r;
        end
        2'd2: begin
          fifo_data_s[2] = bus.q;
          fifo_last_s[2] = inflight_last_r;
        end
        default: begin
          fifo_last_s = fifo_last_s;
        end
      endcase
    end else begin
      wr_idx_s = wr_idx_s;
    end
  end

  // Command FSM, read scheduling, FIFO storage and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r         <= IDLE;
      next_addr_r     <= '0;
      next_elm_r      <= '0;
      raddr_r         <= '0;
      raddr_elm_r     <= '0;
      remain_r        <= '0;
      issue_r         <= 1'b0;
      issue_last_r    <= 1'b0;
      inflight_r      <= 1'b0;
      inflight_last_r <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        fifo_data_r[i] <= '0;
      end
      fifo_last_r     <= 3'b000;
      occ_r           <= 2'd0;
      valid_r         <= 1'b0;
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        fifo_data_r[i] <= fifo_data_s[i];
      end
      fifo_last_r     <= fifo_last_s;
      occ_r           <= occ_s;
      valid_r         <= (occ_s != 2'd0);
      inflight_r      <= issue_r;
      inflight_last_r <= issue_last_r;
      issue_r         <= 1'b0;
      issue_last_r    <= 1'b0;
      done_r          <= 1'b0;
      if (done_r) begin
        busy_r <= 1'b0;
      end else begin
        busy_r <= busy_r;
      end

      case (state_r)
        IDLE: begin
          if (start_ok_s && (bus.length != LEN_WIDTH'(0))) begin
            raddr_r                   <= bus.baseAddr;
            raddr_elm_r               <= bus.baseElm;
            {next_addr_r, next_elm_r} <= advance(bus.baseAddr, bus.baseElm);
            remain_r                  <= bus.length - LEN_WIDTH'(1);
            issue_r                   <= 1'b1;
            issue_last_r              <= (bus.length == LEN_WIDTH'(1));
            busy_r                    <= 1'b1;
            state_r                   <= (bus.length == LEN_WIDTH'(1)) ? DRAIN : RUN;
          end else if (start_ok_s) begin
            // empty command: acknowledge without reading or going busy
            done_r <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          if (credit_ok_s) begin
            raddr_r                   <= next_addr_r;
            raddr_elm_r               <= next_elm_r;
            {next_addr_r, next_elm_r} <= advance(next_addr_r, next_elm_r);
            remain_r                  <= remain_r - LEN_WIDTH'(1);
            issue_r                   <= 1'b1;
            issue_last_r              <= (remain_r == LEN_WIDTH'(1));
            state_r                   <= (remain_r == LEN_WIDTH'(1)) ? DRAIN : RUN;
          end else begin
            state_r <= RUN;
          end
        end
        DRAIN: begin
          if (last_hs_s) begin
            done_r  <= 1'b1;
            state_r <= IDLE;
          end else begin
            state_r <= DRAIN;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.raddr    = raddr_r;
  assign bus.raddrElm = raddr_elm_r;
  assign bus.outData  = fifo_data_r[0];
  assign bus.outLast  = fifo_last_r[0];
  assign bus.outValid = valid_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
endmodule

// File: tb/tb_dual_port_ram_stream_reader.sv
// Directed bench for dual_port_ram_stream_reader. Two instances: A with
// WORDS=4 and B with WORDS=2, both ADDR_WIDTH=2. Each RAM model returns
// addr*WORDS+elm one cycle after the address. Cycle k means the k-th
// negedge after the edge that samples start.
module tb_dual_port_ram_stream_reader;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  dual_port_ram_stream_reader_if #(.ADDR_WIDTH(2), .WORD_SIZE(8), .WORDS(4)) bus_a ();
  dual_port_ram_stream_reader_if #(.ADDR_WIDTH(2), .WORD_SIZE(8), .WORDS(2)) bus_b ();

  dual_port_ram_stream_reader #(.ADDR_WIDTH(2), .WORD_SIZE(8), .WORDS(4)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a)
  );
  dual_port_ram_stream_reader #(.ADDR_WIDTH(2), .WORD_SIZE(8), .WORDS(2)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b)
  );

  // RAM models with one-cycle registered read
  always @(posedge clk) begin
    bus_a.q <= 8'(int'(bus_a.raddr) * 4 + int'(bus_a.raddrElm));
    bus_b.q <= 8'(int'(bus_b.raddr) * 2 + int'(bus_b.raddrElm));
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  int t1_addr [10] = '{2, 2, 2, 3, 3, 3, 3, 3, 3, 3};
  int t1_elm  [10] = '{1, 2, 3, 0, 1, 2, 2, 2, 2, 2};
  int t1_data [6]  = '{9, 10, 11, 12, 13, 14};
  int t2_addr [6]  = '{3, 0, 0, 0, 0, 0};
  int t2_elm  [6]  = '{1, 0, 1, 1, 1, 1};
  int t2_data [3]  = '{7, 0, 1};
  int t5_addr [6]  = '{1, 1, 1, 1, 1, 1};
  int t5_elm  [6]  = '{2, 3, 3, 3, 3, 3};
  int t5_data [2]  = '{6, 7};
  bit pat     [4]  = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    int idx;
    bit got_done;

    bus_a.start = 1'b0; bus_a.baseAddr = 2'd0; bus_a.baseElm = 2'd0;
    bus_a.length = 5'd0; bus_a.outReady = 1'b1;
    bus_b.start = 1'b0; bus_b.baseAddr = 2'd0; bus_b.baseElm = 1'd0;
    bus_b.length = 4'd0; bus_b.outReady = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // reset state
    check_eq("rst_valid", int'(bus_a.outValid), 0);
    check_eq("rst_busy",  int'(bus_a.busy),     0);
    check_eq("rst_done",  int'(bus_a.done),     0);
    check_eq("rst_raddr", int'(bus_a.raddr),    0);
    check_eq("rst_elm",   int'(bus_a.raddrElm), 0);
    check_eq("rst_data",  int'(bus_a.outData),  0);
    check_eq("rst_last",  int'(bus_a.outLast),  0);
    reset = 1'b0;
    @(negedge clk);

    // test 1: base (2,1), length 6, full throughput
    bus_a.baseAddr = 2'd2; bus_a.baseElm = 2'd1; bus_a.length = 5'd6; bus_a.start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      bus_a.start = 1'b0;
      check_eq("t1_raddr", int'(bus_a.raddr),    t1_addr[k-1]);
      check_eq("t1_elm",   int'(bus_a.raddrElm), t1_elm[k-1]);
      check_eq("t1_valid", int'(bus_a.outValid), int'(k >= 3 && k <= 8));
      if (k >= 3 && k <= 8) begin
        check_eq("t1_data", int'(bus_a.outData), t1_data[k-3]);
        check_eq("t1_last", int'(bus_a.outLast), int'(k == 8));
      end
      check_eq("t1_done", int'(bus_a.done), int'(k == 9));
      check_eq("t1_busy", int'(bus_a.busy), int'(k <= 9));
    end

    // test 2: WORDS=2, base (3,1), length 3, address wraps
    bus_b.baseAddr = 2'd3; bus_b.baseElm = 1'd1; bus_b.length = 4'd3; bus_b.start = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      bus_b.start = 1'b0;
      check_eq("t2_raddr", int'(bus_b.raddr),    t2_addr[k-1]);
      check_eq("t2_elm",   int'(bus_b.raddrElm), t2_elm[k-1]);
      check_eq("t2_valid", int'(bus_b.outValid), int'(k >= 3 && k <= 5));
      if (k >= 3 && k <= 5) begin
        check_eq("t2_data", int'(bus_b.outData), t2_data[k-3]);
        check_eq("t2_last", int'(bus_b.outLast), int'(k == 5));
      end
      check_eq("t2_done", int'(bus_b.done), int'(k == 6));
    end

    // test 3: base (1,3), length 10, outReady 1,0,0,1; stray start at k=4
    bus_a.baseAddr = 2'd1; bus_a.baseElm = 2'd3; bus_a.length = 5'd10; bus_a.start = 1'b1;
    idx = 0;
    got_done = 1'b0;
    for (int k = 1; k <= 80 && !got_done; k++) begin
      @(negedge clk);
      bus_a.start = (k == 4);
      if (k == 4) begin
        bus_a.baseAddr = 2'd0; bus_a.baseElm = 2'd0; bus_a.length = 5'd3;
      end
      bus_a.outReady = pat[(k-1) % 4];
      if (bus_a.outValid) begin
        check_eq("t3_data", int'(bus_a.outData), (7 + idx) % 16);
        check_eq("t3_last", int'(bus_a.outLast), int'(idx == 9));
        if (bus_a.outReady) begin
          idx++;
        end
      end
      if (bus_a.done) begin
        got_done = 1'b1;
      end
    end
    bus_a.start = 1'b0;
    bus_a.outReady = 1'b1;
    check_eq("t3_done_seen", int'(got_done), 1);
    check_eq("t3_beats", idx, 10);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check_eq("t3_no_extra", int'(bus_a.outValid), 0);
      check_eq("t3_idle_busy", int'(bus_a.busy), 0);
    end

    // test 4: zero-length command
    bus_a.length = 5'd0; bus_a.start = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      bus_a.start = 1'b0;
      check_eq("t4_done",  int'(bus_a.done),     int'(k == 1));
      check_eq("t4_busy",  int'(bus_a.busy),     0);
      check_eq("t4_valid", int'(bus_a.outValid), 0);
    end

    // test 5: reset in cycle 5 of a 20-element command, then a 2-element command
    bus_a.baseAddr = 2'd0; bus_a.baseElm = 2'd0; bus_a.length = 5'd20; bus_a.start = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      bus_a.start = 1'b0;
    end
    check_eq("t5_pre_valid", int'(bus_a.outValid), 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("t5_rst_valid", int'(bus_a.outValid), 0);
    check_eq("t5_rst_busy",  int'(bus_a.busy),     0);
    check_eq("t5_rst_done",  int'(bus_a.done),     0);
    check_eq("t5_rst_raddr", int'(bus_a.raddr),    0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check_eq("t5_stale_valid", int'(bus_a.outValid), 0);
      check_eq("t5_stale_busy",  int'(bus_a.busy),     0);
    end
    bus_a.baseAddr = 2'd1; bus_a.baseElm = 2'd2; bus_a.length = 5'd2; bus_a.start = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      bus_a.start = 1'b0;
      check_eq("t5_raddr", int'(bus_a.raddr),    t5_addr[k-1]);
      check_eq("t5_elm",   int'(bus_a.raddrElm), t5_elm[k-1]);
      check_eq("t5_valid", int'(bus_a.outValid), int'(k >= 3 && k <= 4));
      if (k >= 3 && k <= 4) begin
        check_eq("t5_data", int'(bus_a.outData), t5_data[k-3]);
        check_eq("t5_last", int'(bus_a.outLast), int'(k == 4));
      end
      check_eq("t5_done", int'(bus_a.done), int'(k == 5));
      check_eq("t5_busy", int'(bus_a.busy), int'(k <= 5));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
